serial_adder_ctrl: RTL and testbench

//  Bit-serial add/subtract engine: one one-bit full-adder cell, time-shared across
//  the operand bits by this controller. Accepts a WIDTH-bit job via valid/ready,

---
 rtl/serial_adder_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add/subtract engine. A single one-bit full-adder cell is reused
// for every operand bit, LSB first, one bit per clock. A job is accepted over a
// valid/ready handshake. The result comes back over a second valid/ready
// handshake and consists of sum, carry-out and signed overflow.
//
// Parameters
//   WIDTH        operand/result width (>= 2); also the number of RUN cycles
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset (aborts any job)
//   start_valid  in   1      job request
//   start_ready  out  1      high only in IDLE
//   op_a         in   WIDTH  operand A, sampled at the start handshake
//   op_b         in   WIDTH  operand B, sampled at the start handshake
//   cin          in   1      carry-in for add; ignored when sub=1
//   sub          in   1      1: A-B, 0: A+B+cin
//   res_valid    out  1      result available (DONE state)
//   res_ready    in   1      consumer accepts result
//   sum          out  WIDTH  registered result
//   cout         out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf          out  1      signed overflow
//   busy         out  1      state != IDLE
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
    logic [WIDTH-1:0]   r_sh_q,  r_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    // The shared full-adder cell
    logic fa_s;
    logic fa_c;
    assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    // Subtraction is A + ~B + 1: invert B and force carry-in.
                    a_sh_d  = op_a;
                    b_sh_d  = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {fa_s, r_sh_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // On the MSB cycle carry_q is the carry into the MSB, so
                    // overflow is that XOR the carry out of the MSB.
                    sum_d   = {fa_s, r_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .sub        (sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .sum        (sum),
        .cout       (cout),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           due;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compare each new result against the head of the scoreboard.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (res_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_res_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("sum", {24'd0, sum}, {24'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                end
            end else if (!res_valid && exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                n_checks++;
                $display("FAIL late_res_valid: got 0 expected 1 (cycle %0d due %0d)", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            prev_vld = res_valid;
        end
    end

    // Issue one job; caller is positioned #1 after a rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, input logic [W-1:0] es, input logic ec, input logic eo);
        int waited = 0;
        exp_t e;
        while (!start_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!start_ready) begin
            n_checks++;
            $display("FAIL start_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        start_valid = 1'b1;
        op_a = a; op_b = b; cin = ci; sub = sb;
        @(posedge clk); #1;
        e.s = es; e.c = ec; e.o = eo; e.due = cyc + W;
        exp_q.push_back(e);
        start_valid = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, back to back with res_ready held high
        for (int i = 0; i < 7; i++)
            issue(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].s, vecs[i].c, vecs[i].o);

        // Backpressure: 0xC0 + 0xA0 = 0x160 -> 0x60, cout=1, ovf=1
        while (busy) begin @(posedge clk); #1; end
        res_ready = 1'b0;
        issue(8'hC0, 8'hA0, 1'b0, 1'b0, 8'h60, 1'b1, 1'b1);
        begin
            int w = 0;
            while (!res_valid && w < 20) begin @(posedge clk); #1; w++; end
        end
        for (int k = 0; k < 5; k++) begin
            start_valid = ~start_valid;
            op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
            @(posedge clk); #1;
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
            chk("bp_sum_held", {24'd0, sum}, 32'h60);
            chk("bp_cout_held", {31'd0, cout}, 32'd1);
        end
        start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_start_ready", {31'd0, start_ready}, 32'd1);
        chk("bp_release_res_valid", {31'd0, res_valid}, 32'd0);
        chk("bp_release_sum", {24'd0, sum}, 32'h60);
        chk("bp_release_ovf", {31'd0, ovf}, 32'd1);

        // Reset during the 3rd RUN cycle aborts the job
        start_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
        @(posedge clk); #1;
        start_valid = 1'b0; op_a = '0; op_b = '0;
        chk("abort_busy_running", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;

        // A fresh job still works after the abort
        issue(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);
        repeat (W + 4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
